seq_divider: RTL and testbench

//  Iterative unsigned restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient + remainder.

---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/seq_divider_if.sv | 33 +++
 rtl/seq_divider_step.sv | 26 ++
 rtl/seq_divider.sv | 124 ++++++++++++
 tb/tb_seq_divider.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
//------------------------------------------------------------------------------
// div_pkg : shared types and constants for the seq_divider restoring divider.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int iter_cnt(input int dw);
    return 2 * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
//------------------------------------------------------------------------------
// seq_divider_if : operand/result handshake bundle of the sequential divider.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     quotient;
  logic [DW-1:0]     remainder;
  logic              err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_step.sv
//------------------------------------------------------------------------------
// div_step : one combinational restoring-division step (shift in a bit, try subtract).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic [DW-1:0] i_rem,
  input  wire logic          i_bit,
  input  wire logic [DW-1:0] i_divisor,
  output logic      [DW-1:0] o_rem,
  output logic               o_qbit
);

  logic [DW:0] w_pr;

  assign w_pr   = {i_rem, i_bit};
  assign o_qbit = (w_pr >= {1'b0, i_divisor});
  // Difference always fits DW bits when the subtract is taken (pr < 2*divisor).
  assign o_rem  = o_qbit ? DW'(w_pr - {1'b0, i_divisor}) : w_pr[DW-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// seq_divider : iterative unsigned restoring divider, 2*DW / DW -> DW quotient + remainder.
// Optional macro DIV_ERR_CHECK_EN enables the divide-by-zero/overflow fast path and err flag.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst,
  seq_divider_if.slave bus
);

  localparam int C_NSTEP = iter_cnt(DW);
  localparam int C_CW    = $clog2(C_NSTEP + 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [C_CW-1:0]  r_cnt;
  logic [2*DW-1:0]  r_dvd;
  logic [DW-1:0]    r_div;
  logic [DW-1:0]    r_rem;
  logic [DW-1:0]    r_qsh;
  logic [DW-1:0]    r_quotient;
  logic [DW-1:0]    r_remainder;
  logic [DW-1:0]    w_rem_nx;
  logic             w_qbit;
  logic             w_accept;
  logic             w_last;
  logic             w_fast;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_state == BUSY) && (r_cnt == C_CW'(1));

`ifdef DIV_ERR_CHECK_EN
  assign w_fast = (bus.divisor == '0) || (bus.dividend[2*DW-1:DW] >= bus.divisor);
`else
  assign w_fast = 1'b0;
`endif

  div_step #(.DW(DW)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[2*DW-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_nx),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? DONE : BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  // Dividend shifts out MSB first; quotient bits shift in from the LSB so only the low DW survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_qsh       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_accept) begin
        r_dvd <= bus.dividend;
        r_div <= bus.divisor;
        r_rem <= '0;
        r_qsh <= '0;
        r_cnt <= C_CW'(C_NSTEP);
        if (w_fast) begin
          r_quotient  <= '1;
          r_remainder <= (bus.divisor == '0) ? bus.dividend[DW-1:0] : '0;
        end
      end else if (r_state == BUSY) begin
        r_dvd <= {r_dvd[2*DW-2:0], 1'b0};
        r_rem <= w_rem_nx;
        r_qsh <= {r_qsh[DW-2:0], w_qbit};
        r_cnt <= r_cnt - C_CW'(1);
      end
      if (w_last) begin
        r_quotient  <= {r_qsh[DW-2:0], w_qbit};
        r_remainder <= w_rem_nx;
      end
    end
  end

`ifdef DIV_ERR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_err <= 1'b0;
    else if (w_accept && w_fast) r_err <= 1'b1;
    else if (w_last)            r_err <= 1'b0;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// tb_seq_divider : directed table, corner sequences and random ops against an arithmetic model.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;
  import div_pkg::*;

  localparam int DW = 16;
`ifdef DIV_ERR_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.DW(DW)) bus ();

  seq_divider #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the error fast path layered on top when enabled.
  function automatic vec_t model(input logic [31:0] dvd, input logic [15:0] dvs);
    vec_t        v;
    logic [31:0] qq;
    v.dvd = dvd;
    v.dvs = dvs;
    v.e   = 1'b0;
    v.lat = 32;
    if (dvs == 16'h0) begin
      v.q = 16'hFFFF;
      v.r = dvd[15:0];
    end else begin
      qq  = dvd / {16'h0, dvs};
      v.q = qq[15:0];
      v.r = 16'(dvd % {16'h0, dvs});
    end
    if (EN && (dvs == 16'h0 || dvd[31:16] >= dvs)) begin
      v.e   = 1'b1;
      v.q   = 16'hFFFF;
      v.r   = (dvs == 16'h0) ? dvd[15:0] : 16'h0;
      v.lat = 0;
    end
    return v;
  endfunction

  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_before_start", bus.in_ready, 1'b1);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input logic busy_ok);
    chk({tag, " out_valid"}, bus.out_valid, 1'b1);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " quotient"}, bus.quotient, v.q);
    chk({tag, " remainder"}, bus.remainder, v.r);
    chk({tag, " err"}, bus.err, v.e);
    chk({tag, " in_ready_low_busy"}, busy_ok, 1'b1);
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid_fall"}, bus.out_valid, 1'b0);
    chk({tag, " in_ready_rise"}, bus.in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int   lat;
    logic busy_ok;
    start_op(v.dvd, v.dvs);
    wait_valid(lat, busy_ok);
    check_result(tag, v, lat, busy_ok);
    take(tag);
  endtask

  vec_t tbl[8];

  initial begin
    int   lat;
    logic busy_ok;
    logic stable;
    logic [15:0] q0, r0;
    logic e0;
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    tbl[0] = '{32'h000186A0, 16'd7,     16'd14285, 16'd5,     1'b0, 32};
    tbl[1] = '{32'h00010000, 16'h0002,  16'h8000,  16'h0000,  1'b0, 32};
    tbl[2] = '{32'hFFFFFFFF, 16'h0001,  16'hFFFF,  16'h0000,  EN,   EN ? 0 : 32};
    tbl[3] = '{32'h12345678, 16'h0000,  16'hFFFF,  16'h5678,  EN,   EN ? 0 : 32};
    tbl[4] = '{32'd1000,     16'd3,     16'd333,   16'd1,     1'b0, 32};
    tbl[5] = '{32'h0000FFFF, 16'hFFFF,  16'h0001,  16'h0000,  1'b0, 32};
    tbl[6] = '{32'hFFFEFFFF, 16'hFFFF,  16'hFFFF,  16'hFFFE,  1'b0, 32};
    tbl[7] = '{32'd5,        16'd7,     16'd0,     16'd5,     1'b0, 32};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", bus.in_ready, 1'b1);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset quotient", bus.quotient, 16'h0);
    chk("reset remainder", bus.remainder, 16'h0);
    chk("reset err", bus.err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-pressure: results hold while out_ready is low; a stray in_valid pulse is ignored.
    v = model(32'h00345678, 16'h1234);
    start_op(v.dvd, v.dvs);
    wait_valid(lat, busy_ok);
    check_result("bp", v, lat, busy_ok);
    q0 = bus.quotient;
    r0 = bus.remainder;
    e0 = bus.err;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        bus.dividend = 32'd99;
        bus.divisor  = 16'd9;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.quotient !== q0 ||
          bus.remainder !== r0 || bus.err !== e0) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp outputs_stable", stable, 1'b1);
    chk("bp quotient_held", bus.quotient, v.q);
    take("bp");
    @(posedge clk); #1;
    chk("bp no_phantom_accept", bus.in_ready, 1'b1);

    // Reset in the middle of an operation.
    start_op(32'h000186A0, 16'd7);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst busy", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 1'b0);
    chk("midrst quotient", bus.quotient, 16'h0);
    chk("midrst remainder", bus.remainder, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", bus.in_ready, 1'b1);
    run_op("after_rst", model(32'd1000, 16'd3));

    for (int k = 0; k < 40; k++) begin
      int          mode;
      logic [31:0] dvd;
      logic [15:0] dvs;
      mode = $urandom_range(0, 9);
      dvd  = $urandom;
      if (mode == 0)     dvs = 16'h0;
      else if (mode < 3) dvs = 16'($urandom_range(1, 15));
      else               dvs = 16'($urandom);
      if (mode >= 5 && dvs != 16'h0) dvd[31:16] = dvd[31:16] % dvs;
      run_op($sformatf("rnd%0d", k), model(dvd, dvs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
